// File: rtl/ru_fault_scheduler_if.sv
// Connects the BIST result collector and RU datapath to the fault scheduler.
// The collector side drives test results and requests; the scheduler side answers with the fault table and step index.
interface ru_fault_scheduler_if #(
  parameter int ROWS   = 4,
  parameter int COLS   = 4,
  parameter int NUM_RU = 4,
  parameter int K_LEN  = 4
);
  localparam int RW = (ROWS  > 1) ? $clog2(ROWS)  : 1;
  localparam int CW = (COLS  > 1) ? $clog2(COLS)  : 1;
  localparam int KW = (K_LEN > 1) ? $clog2(K_LEN) : 1;
  localparam int FW = $clog2(ROWS*COLS+1);

  logic [ROWS*COLS-1:0]  stw_result;
  logic                  scan_start;
  logic                  recompute_start;
  logic                  scan_busy;
  logic                  scan_done;
  logic [FW-1:0]         fault_count;
  logic                  overflow;
  logic [NUM_RU-1:0]     ru_valid;
  logic [NUM_RU*RW-1:0]  ru_row;
  logic [NUM_RU*CW-1:0]  ru_col;
  logic                  recompute_busy;
  logic                  step_valid;
  logic [KW-1:0]         ru_k;
  logic                  recompute_done;

  modport master (
    output stw_result, scan_start, recompute_start,
    input  scan_busy, scan_done, fault_count, overflow, ru_valid, ru_row, ru_col,
    input  recompute_busy, step_valid, ru_k, recompute_done
  );

  modport slave (
    input  stw_result, scan_start, recompute_start,
    output scan_busy, scan_done, fault_count, overflow, ru_valid, ru_row, ru_col,
    output recompute_busy, step_valid, ru_k, recompute_done
  );
endinterface

// File: rtl/ru_fault_scheduler.sv
// Scans the PE self-test matrix in row-major order, then assigns faulty PEs to recompute-unit slots.
// It then steps the shared reduction index for the lockstep recompute sequence.
module ru_fault_scheduler #(
  parameter int ROWS   = 4,
  parameter int COLS   = 4,
  parameter int NUM_RU = 4,
  parameter int K_LEN  = 4
) (
  input logic                clk,
  input logic                rst,
  ru_fault_scheduler_if.slave bus
);
  localparam int RW  = (ROWS  > 1) ? $clog2(ROWS)  : 1;
  localparam int CW  = (COLS  > 1) ? $clog2(COLS)  : 1;
  localparam int KW  = (K_LEN > 1) ? $clog2(K_LEN) : 1;
  localparam int NPE = ROWS * COLS;
  localparam int FW  = $clog2(NPE + 1);

  localparam logic [FW-1:0] P_LAST = FW'(NPE - 1);
  localparam logic [CW-1:0] C_LAST = CW'(COLS - 1);
  localparam logic [KW-1:0] K_LAST = KW'(K_LEN - 1);

  typedef enum logic [1:0] {IDLE, SCAN, READY, RECOMPUTE} state_t;

  state_t        state;
  logic [FW-1:0] p;
  logic [RW-1:0] r_q;
  logic [CW-1:0] c_q;

  logic           scan_req;
  logic           pe_faulty;
  logic           slot_free;
  logic [NPE-1:0] stw_shift;

  // Row/column are tracked as counters alongside p, so no divider is needed for p/COLS and p%COLS.
  always_comb begin
    scan_req  = bus.scan_start && (state == IDLE || state == READY);
    stw_shift = bus.stw_result >> p;
    pe_faulty = ~stw_shift[0];
    slot_free = 32'(bus.fault_count) < 32'(NUM_RU);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state               <= IDLE;
      p                   <= '0;
      r_q                 <= '0;
      c_q                 <= '0;
      bus.scan_busy       <= 1'b0;
      bus.scan_done       <= 1'b0;
      bus.fault_count     <= '0;
      bus.overflow        <= 1'b0;
      bus.ru_valid        <= '0;
      bus.ru_row          <= '0;
      bus.ru_col          <= '0;
      bus.recompute_busy  <= 1'b0;
      bus.step_valid      <= 1'b0;
      bus.ru_k            <= '0;
      bus.recompute_done  <= 1'b0;
    end else begin
      bus.scan_done      <= 1'b0;
      bus.recompute_done <= 1'b0;
      if (scan_req) begin
        // Slot row/col are cleared too so that unassigned slots read as zero.
        state           <= SCAN;
        p               <= '0;
        r_q             <= '0;
        c_q             <= '0;
        bus.scan_busy   <= 1'b1;
        bus.fault_count <= '0;
        bus.overflow    <= 1'b0;
        bus.ru_valid    <= '0;
        bus.ru_row      <= '0;
        bus.ru_col      <= '0;
      end else begin
        case (state)
          IDLE: ;
          SCAN: begin
            if (pe_faulty) begin
              bus.fault_count <= bus.fault_count + FW'(1);
              if (slot_free) begin
                for (int unsigned n = 0; n < NUM_RU; n++) begin
                  if (32'(bus.fault_count) == n) begin
                    bus.ru_row[n*RW +: RW] <= r_q;
                    bus.ru_col[n*CW +: CW] <= c_q;
                    bus.ru_valid[n]        <= 1'b1;
                  end
                end
              end else begin
                bus.overflow <= 1'b1;
              end
            end
            if (c_q == C_LAST) begin
              c_q <= '0;
              r_q <= r_q + RW'(1);
            end else begin
              c_q <= c_q + CW'(1);
            end
            if (p == P_LAST) begin
              p             <= '0;
              bus.scan_busy <= 1'b0;
              bus.scan_done <= 1'b1;
              state         <= READY;
            end else begin
              p <= p + FW'(1);
            end
          end
          READY: begin
            if (bus.recompute_start) begin
              if (|bus.ru_valid) begin
                state              <= RECOMPUTE;
                bus.recompute_busy <= 1'b1;
                bus.step_valid     <= 1'b1;
                bus.ru_k           <= '0;
              end else begin
                bus.recompute_done <= 1'b1;
              end
            end
          end
          RECOMPUTE: begin
            if (bus.ru_k == K_LAST) begin
              bus.ru_k           <= '0;
              bus.step_valid     <= 1'b0;
              bus.recompute_busy <= 1'b0;
              bus.recompute_done <= 1'b1;
              state              <= READY;
            end else begin
              bus.ru_k <= bus.ru_k + KW'(1);
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_ru_fault_scheduler.sv
// Directed bench for ru_fault_scheduler on a 4x4 array with 4 RU slots and K_LEN=4.
// Expected fault tables and step indices go through scoreboard queues and are compared when the design reports them.
module tb_ru_fault_scheduler;
  localparam int ROWS = 4, COLS = 4, NUM_RU = 4, K_LEN = 4;
  localparam int RW = 2, CW = 2, KW = 2, FW = 5, NPE = ROWS * COLS;

  typedef struct {
    logic [FW-1:0]        fc;
    logic                 ov;
    logic [NUM_RU-1:0]    v;
    logic [NUM_RU*RW-1:0] rr;
    logic [NUM_RU*CW-1:0] cc;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  exp_t        sb[$];
  logic [KW-1:0] kq[$];
  exp_t        cur;

  always #5 clk = ~clk;

  ru_fault_scheduler_if #(.ROWS(ROWS), .COLS(COLS), .NUM_RU(NUM_RU), .K_LEN(K_LEN)) bus ();

  ru_fault_scheduler #(.ROWS(ROWS), .COLS(COLS), .NUM_RU(NUM_RU), .K_LEN(K_LEN)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input logic [NPE-1:0] pat);
    exp_t e;
    int   fc = 0;
    e.fc = '0; e.ov = 1'b0; e.v = '0; e.rr = '0; e.cc = '0;
    for (int i = 0; i < NPE; i++) begin
      if (!pat[i]) begin
        if (fc < NUM_RU) begin
          e.rr[fc*RW +: RW] = RW'(i / COLS);
          e.cc[fc*CW +: CW] = CW'(i % COLS);
          e.v[fc]           = 1'b1;
        end
        fc++;
      end
    end
    e.fc = FW'(fc);
    e.ov = (fc > NUM_RU);
    return e;
  endfunction

  task automatic check_zero(input string tag);
    check({tag, ".scan_busy"},      bus.scan_busy,      0);
    check({tag, ".scan_done"},      bus.scan_done,      0);
    check({tag, ".fault_count"},    bus.fault_count,    0);
    check({tag, ".overflow"},       bus.overflow,       0);
    check({tag, ".ru_valid"},       bus.ru_valid,       0);
    check({tag, ".ru_row"},         bus.ru_row,         0);
    check({tag, ".ru_col"},         bus.ru_col,         0);
    check({tag, ".recompute_busy"}, bus.recompute_busy, 0);
    check({tag, ".step_valid"},     bus.step_valid,     0);
    check({tag, ".ru_k"},           bus.ru_k,           0);
    check({tag, ".recompute_done"}, bus.recompute_done, 0);
  endtask

  task automatic check_table(input string tag, input exp_t e);
    check({tag, ".fault_count"}, bus.fault_count, e.fc);
    check({tag, ".overflow"},    bus.overflow,    e.ov);
    check({tag, ".ru_valid"},    bus.ru_valid,    e.v);
    check({tag, ".ru_row"},      bus.ru_row,      e.rr);
    check({tag, ".ru_col"},      bus.ru_col,      e.cc);
  endtask

  // Starts a scan at a negedge; optionally raises recompute_start in the same cycle.
  task automatic run_scan(input string tag, input logic [NPE-1:0] pat, input bit with_rec);
    int   busy_cnt = 0;
    int   done_idx = -1;
    bit   sv_seen  = 0;
    exp_t e;
    bus.stw_result      = pat;
    bus.scan_start      = 1'b1;
    bus.recompute_start = with_rec;
    sb.push_back(model(pat));
    @(negedge clk);
    bus.scan_start      = 1'b0;
    bus.recompute_start = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (bus.step_valid || bus.recompute_busy) sv_seen = 1;
      if (bus.scan_done) begin
        done_idx = i;
        break;
      end
      if (bus.scan_busy) busy_cnt++;
      @(negedge clk);
    end
    check({tag, ".done_latency"}, done_idx, NPE);
    check({tag, ".busy_cycles"},  busy_cnt, NPE);
    check({tag, ".busy_at_done"}, bus.scan_busy, 0);
    check({tag, ".no_steps"},     sv_seen, 0);
    check({tag, ".sb_pending"},   sb.size(), 1);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check_table(tag, e);
      cur = e;
    end
    @(negedge clk);
    check({tag, ".done_pulse"}, bus.scan_done, 0);
    check({tag, ".no_rec_after"}, bus.recompute_busy, 0);
  endtask

  task automatic run_recompute(input string tag, input bit retrigger);
    int exp_done = (cur.v != 0) ? K_LEN : 0;
    int done_idx = -1;
    int steps    = 0;
    bus.recompute_start = 1'b1;
    if (cur.v != 0)
      for (int k = 0; k < K_LEN; k++) kq.push_back(KW'(k));
    @(negedge clk);
    bus.recompute_start = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (bus.step_valid) begin
        steps++;
        if (kq.size() > 0) check({tag, ".ru_k"}, bus.ru_k, kq.pop_front());
        else               check({tag, ".unexpected_step"}, 1, 0);
        check({tag, ".busy_with_step"}, bus.recompute_busy, 1);
      end
      if (bus.recompute_done) begin
        done_idx = i;
        break;
      end
      bus.recompute_start = (retrigger && i == 1);
      @(negedge clk);
    end
    bus.recompute_start = 1'b0;
    check({tag, ".done_latency"}, done_idx, exp_done);
    check({tag, ".steps_left"},   kq.size(), 0);
    check({tag, ".step_count"},   steps, (cur.v != 0) ? K_LEN : 0);
    check({tag, ".sv_at_done"},   bus.step_valid, 0);
    check({tag, ".busy_at_done"}, bus.recompute_busy, 0);
    check({tag, ".k_at_done"},    bus.ru_k, 0);
    check_table({tag, ".table"}, cur);
    kq.delete();
    @(negedge clk);
    check({tag, ".done_pulse"}, bus.recompute_done, 0);
    check({tag, ".sv_after"},   bus.step_valid, 0);
  endtask

  initial begin
    logic [NPE-1:0] pat2;
    logic [NPE-1:0] pat3;
    bit             found;
    pat2 = 16'hFFFF & ~(16'(1) << 6) & ~(16'(1) << 12);
    pat3 = 16'hFFFF & ~16'h8629;
    bus.stw_result      = '1;
    bus.scan_start      = 1'b0;
    bus.recompute_start = 1'b0;
    cur = model('1);

    repeat (3) @(negedge clk);
    check_zero("reset");
    rst = 1'b0;
    @(negedge clk);
    check_zero("post_reset");

    // Idle ignores recompute_start.
    bus.recompute_start = 1'b1;
    @(negedge clk);
    bus.recompute_start = 1'b0;
    @(negedge clk);
    check("idle_rec.done", bus.recompute_done, 0);
    check("idle_rec.busy", bus.recompute_busy, 0);

    run_scan("s1_allpass", '1, 0);
    run_recompute("s6_zero_rec", 0);

    run_scan("s2_two", pat2, 0);
    check("s2.slot0", {bus.ru_row[1:0], bus.ru_col[1:0]}, {2'd1, 2'd2});
    check("s2.slot1", {bus.ru_row[3:2], bus.ru_col[3:2]}, {2'd3, 2'd0});
    run_recompute("s4_rec", 1);
    run_recompute("s4_rec2", 0);

    // Simultaneous scan_start/recompute_start in READY: scan wins.
    run_scan("s4_simul_s3", pat3, 1);
    check("s3.rows", bus.ru_row, {2'd2, 2'd1, 2'd0, 2'd0});
    check("s3.cols", bus.ru_col, {2'd1, 2'd1, 2'd3, 2'd0});
    check("s3.count", bus.fault_count, 6);
    run_recompute("s3_rec_overflow", 0);

    // Reset mid-scan at p=7.
    bus.stw_result = pat3;
    bus.scan_start = 1'b1;
    @(negedge clk);
    bus.scan_start = 1'b0;
    repeat (7) @(negedge clk);
    check("s5_scan.busy_before", bus.scan_busy, 1);
    #2 rst = 1'b1;
    #1 check_zero("s5_scan_rst");
    @(negedge clk);
    rst = 1'b0;
    bus.recompute_start = 1'b1;
    @(negedge clk);
    bus.recompute_start = 1'b0;
    @(negedge clk);
    check("s5_scan.idle_rec_done", bus.recompute_done, 0);
    run_scan("s5_rescan", pat2, 0);

    // Reset mid-recompute at ru_k=2.
    bus.recompute_start = 1'b1;
    @(negedge clk);
    bus.recompute_start = 1'b0;
    found = 0;
    for (int i = 0; i < 10; i++) begin
      if (bus.step_valid && bus.ru_k == 2) begin
        found = 1;
        break;
      end
      @(negedge clk);
    end
    check("s5_rec.reached_k2", found, 1);
    #2 rst = 1'b1;
    #1 check_zero("s5_rec_rst");
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_zero("s5_rec_idle");
    run_scan("s5_rescan2", pat2, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
